// File: rtl/queue_burst_sched.sv
// Burst scheduler sharing one FIR MAC datapath between two circular sample queues.
// Optional build macro SCHED_FIXED_PRI_EN: on a tie queue 1 always wins instead of round robin.
module queue_burst_sched #(
  parameter int BURST_LEN = 1021,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [1:0] seq,
  output logic       mac_en,
  output logic       mac_first,
  output logic       done,
  output logic       done_id,
  output logic       busy,
  output logic [1:0] ovr
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               id_q, id_d;
  logic               last_id_q, last_id_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         ovr_q, ovr_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         seq_q, seq_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic               busy_q, busy_d;
  logic [RD_LAT-1:0]  en_pipe_q, en_pipe_d;
  logic [RD_LAT-1:0]  first_pipe_q, first_pipe_d;

  logic               grant;
  logic               sel_id;
  logic [1:0]         pend_eff;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    grant     = 1'b0;
    sel_id    = 1'b0;
    // A request arriving in the arbitration cycle itself is eligible immediately.
    pend_eff  = pend_q | req;

    unique case (state_q)
      IDLE: begin
        if (pend_eff != 2'b00) begin
          grant = 1'b1;
          case (pend_eff)
            2'b01:   sel_id = 1'b0;
            2'b10:   sel_id = 1'b1;
`ifdef SCHED_FIXED_PRI_EN
            default: sel_id = 1'b1;
`else
            default: sel_id = ~last_id_q;
`endif
          endcase
          state_d   = BURST;
          id_d      = sel_id;
          last_id_d = sel_id;
          cnt_d     = '0;
        end
      end
      BURST: begin
        if (cnt_q == BURST_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // The counter is reused to wait out the RAM read latency.
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < 2; i++) begin
      if (grant && (int'(sel_id) == i)) begin
        // A fresh request on top of the one being granted stays queued.
        pend_d[i] = pend_q[i] & req[i];
      end else begin
        if (req[i] && pend_q[i]) ovr_d[i] = 1'b1;
        pend_d[i] = pend_q[i] | req[i];
      end
    end

    gnt_d     = grant ? {sel_id, ~sel_id} : 2'b00;
    seq_d     = (state_d == BURST) ? {id_d, ~id_d} : 2'b00;
    done_d    = (state_d == DONE);
    done_id_d = (state_d == DONE) & id_q;
    busy_d    = (state_d != IDLE);

    en_pipe_d       = en_pipe_q;
    first_pipe_d    = first_pipe_q;
    en_pipe_d[0]    = |seq_q;
    first_pipe_d[0] = |gnt_q;
    for (int k = 1; k < RD_LAT; k++) begin
      en_pipe_d[k]    = en_pipe_q[k-1];
      first_pipe_d[k] = first_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_id_q    <= 1'b1;
      pend_q       <= 2'b00;
      ovr_q        <= 2'b00;
      gnt_q        <= 2'b00;
      seq_q        <= 2'b00;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      busy_q       <= 1'b0;
      en_pipe_q    <= '0;
      first_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_id_q    <= last_id_d;
      pend_q       <= pend_d;
      ovr_q        <= ovr_d;
      gnt_q        <= gnt_d;
      seq_q        <= seq_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      busy_q       <= busy_d;
      en_pipe_q    <= en_pipe_d;
      first_pipe_q <= first_pipe_d;
    end
  end

  assign gnt       = gnt_q;
  assign seq       = seq_q;
  assign mac_en    = en_pipe_q[RD_LAT-1];
  assign mac_first = first_pipe_q[RD_LAT-1];
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign busy      = busy_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_queue_burst_sched.sv
// Bench for queue_burst_sched: directed scenarios plus random request traffic
// checked cycle by cycle against a timeline model of burst start times.
module tb_queue_burst_sched;

  localparam int L = 4;
  localparam int R = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt, seq, ovr;
  logic       mac_en, mac_first, done, done_id, busy;

  queue_burst_sched #(.BURST_LEN(L), .RD_LAT(R), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .seq(seq),
    .mac_en(mac_en), .mac_first(mac_first), .done(done), .done_id(done_id),
    .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a burst is fully described by its start cycle and queue id.
  int       cyc;
  bit       act;
  int       s;
  bit       bid;
  bit       last_id;
  bit [1:0] pend;
  bit [1:0] ovr_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input bit b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    act = 0; s = 0; bid = 0; last_id = 1; pend = 2'b00; ovr_m = 2'b00;
  endtask

  task automatic check_outputs();
    logic [1:0] e_gnt, e_seq;
    logic       e_en, e_first, e_done, e_did, e_busy;
    e_gnt   = (act && cyc == s) ? oh(bid) : 2'b00;
    e_seq   = (act && cyc >= s && cyc < s + L) ? oh(bid) : 2'b00;
    e_en    = act && cyc >= s + R && cyc < s + R + L;
    e_first = act && cyc == s + R;
    e_done  = act && cyc == s + R + L;
    e_did   = e_done & bid;
    e_busy  = act && cyc >= s && cyc <= s + R + L;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("seq", 32'(seq), 32'(e_seq));
    check("mac_en", 32'(mac_en), 32'(e_en));
    check("mac_first", 32'(mac_first), 32'(e_first));
    check("done", 32'(done), 32'(e_done));
    check("done_id", 32'(done_id), 32'(e_did));
    check("busy", 32'(busy), 32'(e_busy));
    check("ovr", 32'(ovr), 32'(ovr_m));
  endtask

  task automatic model_update(input bit [1:0] r);
    bit       idle;
    bit [1:0] eff;
    bit       g;
    bit       gid;
    idle = !act || cyc > s + R + L;
    eff  = pend | r;
    g    = idle && (eff != 2'b00);
    gid  = 0;
    if (g) begin
      if (eff == 2'b01) gid = 0;
      else if (eff == 2'b10) gid = 1;
      else begin
`ifdef SCHED_FIXED_PRI_EN
        gid = 1;
`else
        gid = !last_id;
`endif
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (g && gid == i[0]) pend[i] = pend[i] && r[i];
      else begin
        if (pend[i] && r[i]) ovr_m[i] = 1;
        pend[i] = pend[i] | r[i];
      end
    end
    if (g) begin
      act = 1; s = cyc + 1; bid = gid; last_id = gid;
    end
  endtask

  // Called at a falling edge: check this cycle, drive req, advance one cycle.
  task automatic step(input logic [1:0] r);
    check_outputs();
    req = r;
    model_update(r);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_seq"}, 32'(seq), 32'd0);
    check({tag, "_mac_en"}, 32'(mac_en), 32'd0);
    check({tag, "_mac_first"}, 32'(mac_first), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_done_id"}, 32'(done_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovr"}, 32'(ovr), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    cyc   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single id0 burst.
    step(2'b01);
    idle_steps(10);
    // Simultaneous requests: arbitration order.
    step(2'b11);
    idle_steps(16);
    // Extra id1 request two cycles into an id1 burst.
    step(2'b10);
    step(2'b00);
    step(2'b10);
    idle_steps(16);
    // Two extra id1 requests inside one burst: second is an overrun.
    step(2'b10);
    step(2'b00);
    step(2'b10);
    step(2'b10);
    idle_steps(16);

    // Reset mid-burst at cnt=2 clears everything, including ovr.
    step(2'b01);
    step(2'b00);
    step(2'b00);
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    idle_steps(5);
    // Request coincident with the visible grant of the same queue.
    step(2'b10);
    step(2'b10);
    idle_steps(16);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(r);
    end
    idle_steps(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
